// File: rtl/servo_pkg.sv
// Shared types and constants for the two-axis servo slew controller.
package servo_pkg;

    localparam int unsigned AXIS_W               = 8;
    localparam int unsigned POS_W                = 2 * AXIS_W;
    localparam int unsigned FRAME_CYCLES_DEFAULT = 1000000;

    localparam logic [AXIS_W-1:0] CENTER_POS = 8'd128;

    // pos_out / target word layout: {yaw, pitch}
    localparam int unsigned PITCH_LSB = 0;
    localparam int unsigned YAW_LSB   = AXIS_W;

    localparam logic [POS_W-1:0] CENTER_WORD = {CENTER_POS, CENTER_POS};

    typedef enum logic {
        IDLE = 1'b0,
        SLEW = 1'b1
    } state_e;

endpackage

// File: rtl/servo_axis_slew.sv
// One axis of the slew limiter: moves pos toward target by at most STEP_SIZE,
// clamping so it never overshoots or wraps.
module servo_axis_slew
    import servo_pkg::*;
#(
    parameter int unsigned STEP_SIZE = 1
) (
    input  logic [AXIS_W-1:0] pos,
    input  logic [AXIS_W-1:0] target,
    input  logic              step_en,
    output logic [AXIS_W-1:0] next_pos_c
);

    localparam int unsigned DIFF_W = AXIS_W + 1;

    logic signed [DIFF_W-1:0] diff_c;
    logic        [DIFF_W-1:0] mag_c;
    logic        [AXIS_W-1:0] step_c;

    always_comb begin
        diff_c     = $signed({1'b0, target}) - $signed({1'b0, pos});
        mag_c      = diff_c[DIFF_W-1] ? $unsigned(-diff_c) : $unsigned(diff_c);
        step_c     = (mag_c > DIFF_W'(STEP_SIZE)) ? AXIS_W'(STEP_SIZE) : mag_c[AXIS_W-1:0];
        next_pos_c = pos;
        if (step_en) begin
            next_pos_c = diff_c[DIFF_W-1] ? (pos - step_c) : (pos + step_c);
        end
    end

endmodule

// File: rtl/servo_slew_ctrl.sv
// Two-axis servo position slew controller: accepts pitch/yaw targets and
// steps the commanded position toward them once per step interval.
module servo_slew_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEFAULT,
    parameter int unsigned STEP_FRAMES  = 1,
    parameter int unsigned STEP_SIZE    = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [AXIS_W-1:0] tgt_pitch,
    input  logic [AXIS_W-1:0] tgt_yaw,
    input  logic              center,
    output logic [POS_W-1:0]  pos_out,
    output logic              load,
    output logic              busy
);

    localparam int unsigned FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned DIV_W = 8;

    localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(FRAME_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(STEP_FRAMES - 1);

    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  tgt_q, tgt_d;
    state_e            state_q, state_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              tgt_ready_q, tgt_ready_d;

    logic              frame_tick_c;
    logic              step_en_c;
    logic              axis_step_c;
    logic [AXIS_W-1:0] next_pitch_c;
    logic [AXIS_W-1:0] next_yaw_c;

    // Frame timebase and step divider
    always_comb begin
        frame_tick_c = (frame_cnt_q == FRAME_LAST);
        step_en_c    = frame_tick_c && (div_q == DIV_LAST);
        frame_cnt_d  = frame_tick_c ? '0 : frame_cnt_q + FC_W'(1);
        div_d        = div_q;
        if (frame_tick_c) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
        axis_step_c = step_en_c && (state_q == SLEW);
    end

    servo_axis_slew #(.STEP_SIZE(STEP_SIZE)) u_pitch (
        .pos        (pos_q[PITCH_LSB +: AXIS_W]),
        .target     (tgt_q[PITCH_LSB +: AXIS_W]),
        .step_en    (axis_step_c),
        .next_pos_c (next_pitch_c)
    );

    servo_axis_slew #(.STEP_SIZE(STEP_SIZE)) u_yaw (
        .pos        (pos_q[YAW_LSB +: AXIS_W]),
        .target     (tgt_q[YAW_LSB +: AXIS_W]),
        .step_en    (axis_step_c),
        .next_pos_c (next_yaw_c)
    );

    // Next-state and registered outputs; steps always use the pre-accept target
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        tgt_d       = tgt_q;
        load_d      = frame_tick_c;
        busy_d      = 1'b0;
        tgt_ready_d = ~center;

        pos_d[PITCH_LSB +: AXIS_W] = next_pitch_c;
        pos_d[YAW_LSB +: AXIS_W]   = next_yaw_c;

        if (center) begin
            tgt_d = CENTER_WORD;
        end else if (tgt_valid && tgt_ready_q) begin
            tgt_d[PITCH_LSB +: AXIS_W] = tgt_pitch;
            tgt_d[YAW_LSB +: AXIS_W]   = tgt_yaw;
        end

        state_d = (pos_d != tgt_d) ? SLEW : IDLE;
        busy_d  = (state_d == SLEW);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_cnt_q <= '0;
            div_q       <= '0;
            pos_q       <= CENTER_WORD;
            tgt_q       <= CENTER_WORD;
            state_q     <= IDLE;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            tgt_ready_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            div_q       <= div_d;
            pos_q       <= pos_d;
            tgt_q       <= tgt_d;
            state_q     <= state_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            tgt_ready_q <= tgt_ready_d;
        end
    end

    assign pos_out   = pos_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign tgt_ready = tgt_ready_q;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Scoreboard bench for servo_slew_ctrl: stimulus queues the expected
// {pos_out, busy} per frame, the monitor checks them on every load strobe.
module tb_servo_slew_ctrl;

    localparam int unsigned FRAME = 100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [7:0]  tgt_pitch;
    logic [7:0]  tgt_yaw;
    logic        center;
    logic [15:0] pos_out;
    logic        load;
    logic        busy;

    typedef struct packed {
        logic [15:0] pos;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   loads_seen = 0;

    servo_slew_ctrl #(
        .FRAME_CYCLES (FRAME),
        .STEP_FRAMES  (1),
        .STEP_SIZE    (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_pitch (tgt_pitch),
        .tgt_yaw   (tgt_yaw),
        .center    (center),
        .pos_out   (pos_out),
        .load      (load),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] pos, input logic b);
        exp_t e;
        e.pos  = pos;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    // Returns on the falling edge of the cycle in which the next load is seen
    task automatic wait_load();
        int start;
        bit seen;
        start = loads_seen;
        seen  = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (loads_seen != start) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_load: no load within 150 cycles at %0t", $time);
        end
    endtask

    // Offer a target for one cycle starting at the current falling edge
    task automatic accept(input logic [7:0] p, input logic [7:0] y);
        check("tgt_ready_before_accept", 32'(tgt_ready), 32'd1);
        tgt_pitch = p;
        tgt_yaw   = y;
        tgt_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    // Monitor: pops one expectation per load and checks load spacing
    initial begin
        int  since;
        bit  rst_edge;
        exp_t e;
        since = 0;
        forever begin
            @(posedge clk);
            rst_edge = !resetn;
            #1;
            if (rst_edge) since = 0;
            else since++;
            if (load) begin
                loads_seen++;
                check("load_interval", 32'(since), 32'(FRAME));
                since = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: pos_out %h with empty queue at %0t", pos_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("load_pos", 32'(pos_out), 32'(e.pos));
                    check("load_busy", 32'(busy), 32'(e.busy));
                end
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        tgt_valid = 1'b0;
        tgt_pitch = 8'h00;
        tgt_yaw   = 8'h00;
        center    = 1'b0;

        // Reset state and first load timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pos", 32'(pos_out), 32'h8080);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_ready", 32'(tgt_ready), 32'd0);
        push(16'h8080, 1'b0);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_release", 32'(tgt_ready), 32'd1);
        wait_load();

        // Mid-slew retarget: 0x88 heading to 0xA0, new target 0x80
        accept(8'hA0, 8'h80);
        check("busy_after_accept", 32'(busy), 32'd1);
        push(16'h8084, 1'b1); wait_load();
        push(16'h8088, 1'b1); wait_load();
        accept(8'h80, 8'h80);
        push(16'h8084, 1'b1); wait_load();
        push(16'h8080, 1'b0); wait_load();

        // Basic slew to pitch 0x90
        accept(8'h90, 8'h80);
        push(16'h8084, 1'b1); wait_load();
        push(16'h8088, 1'b1); wait_load();
        push(16'h808C, 1'b1); wait_load();
        push(16'h8090, 1'b0); wait_load();

        // Accept in the step_en cycle: that step still uses the old target
        accept(8'hA0, 8'h80);
        push(16'h8094, 1'b1); wait_load();
        push(16'h8098, 1'b1);
        repeat (FRAME - 1) @(posedge clk);
        @(negedge clk);
        accept(8'h80, 8'h80);
        check("busy_after_step_accept", 32'(busy), 32'd1);
        push(16'h8094, 1'b1); wait_load();
        push(16'h8090, 1'b1); wait_load();
        push(16'h808C, 1'b1); wait_load();
        push(16'h8088, 1'b1); wait_load();
        push(16'h8084, 1'b1); wait_load();
        push(16'h8080, 1'b0); wait_load();

        // Center has priority over a simultaneous target offer
        center    = 1'b1;
        tgt_valid = 1'b1;
        tgt_pitch = 8'h10;
        tgt_yaw   = 8'h10;
        @(posedge clk);
        @(negedge clk);
        check("center_ready", 32'(tgt_ready), 32'd0);
        check("center_busy", 32'(busy), 32'd0);
        check("center_pos", 32'(pos_out), 32'h8080);
        center    = 1'b0;
        tgt_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_center", 32'(tgt_ready), 32'd1);
        push(16'h8080, 1'b0); wait_load();

        // Small move finishes in one step without overshoot
        accept(8'h82, 8'h80);
        push(16'h8082, 1'b0); wait_load();

        // Yaw down to 0x02, then to 0x00 without wrapping
        accept(8'h82, 8'h02);
        for (int k = 1; k <= 32; k++) begin
            logic [7:0] y;
            y = (k == 32) ? 8'h02 : 8'(128 - 4 * k);
            push({y, 8'h82}, k != 32);
            wait_load();
        end
        accept(8'h82, 8'h00);
        push(16'h0082, 1'b0); wait_load();

        // Reset mid-slew abandons the move
        accept(8'hA0, 8'h00);
        push(16'h0086, 1'b1); wait_load();
        repeat (50) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_pos", 32'(pos_out), 32'h8080);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_load", 32'(load), 32'd0);
        check("midrst_ready", 32'(tgt_ready), 32'd0);
        push(16'h8080, 1'b0);
        resetn = 1'b1;
        wait_load();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
